core_array_gbus_sched: RTL

CORE_ARRAY_GBUS_SCHED -- requirements
Module: core_array_gbus_sched

---
 rtl/core_array_gbus_sched_if.sv | 37 +++
 rtl/core_array_gbus_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/core_array_gbus_sched_if.sv
// Host-side command / write-stream / read-stream bundle of the gbus scheduler.
interface core_array_gbus_sched_if #(
  parameter int HNUM      = 8,
  parameter int VNUM      = 8,
  parameter int GBUS_DATA = 64,
  parameter int GBUS_ADDR = 12
);
  localparam int RW = (HNUM > 1) ? $clog2(HNUM) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [RW-1:0]        cmd_row;
  logic [VNUM-1:0]      cmd_col_mask;
  logic [GBUS_ADDR-1:0] cmd_addr;
  logic [GBUS_ADDR-1:0] cmd_len;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [GBUS_DATA-1:0] wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [GBUS_DATA-1:0] rd_data;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport slave (
    input  cmd_valid, cmd_write, cmd_row, cmd_col_mask, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );
  modport master (
    output cmd_valid, cmd_write, cmd_row, cmd_col_mask, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );
endinterface

// File: rtl/core_array_gbus_sched.sv
// Sequences host commands onto per-row global buses: broadcast writes to masked
// cores, single-core reads with one outstanding request and a per-word timeout.
module core_array_gbus_sched #(
  parameter int HNUM      = 8,
  parameter int VNUM      = 8,
  parameter int GBUS_DATA = 64,
  parameter int GBUS_ADDR = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rstn,
  core_array_gbus_sched_if.slave      io,
  output logic [HNUM*GBUS_ADDR-1:0]   in_GBUS_ADDR,
  output logic [HNUM*VNUM-1:0]        gbus_wen,
  output logic [HNUM*GBUS_DATA-1:0]   gbus_wdata,
  output logic [HNUM*VNUM-1:0]        gbus_ren,
  input  logic [HNUM*GBUS_DATA-1:0]   gbus_rdata,
  input  logic [HNUM*VNUM-1:0]        gbus_rvalid
);
  localparam int RW = (HNUM > 1) ? $clog2(HNUM) : 1;
  localparam int CW = (VNUM > 1) ? $clog2(VNUM) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW:0]   HNUM_W = (RW+1)'(HNUM);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_OUT, DONE} state_t;
  state_t state, state_n;

  logic [RW-1:0]        row_q;
  logic [VNUM-1:0]      mask_q;
  logic [CW-1:0]        tgt_q;
  logic [GBUS_ADDR-1:0] addr_q, rem_q;
  logic [TW-1:0]        timer_q;
  logic                 err_q;
  logic [GBUS_DATA-1:0] rd_data_q;

  logic [HNUM-1:0][GBUS_ADDR-1:0] addr_r;
  logic [HNUM-1:0][GBUS_DATA-1:0] wdata_r;
  logic [HNUM-1:0][VNUM-1:0]      wen_r, ren_r;
  logic [HNUM-1:0][VNUM-1:0]      rv2;
  logic [HNUM-1:0][GBUS_DATA-1:0] rd2;

  logic cmd_fire, cmd_bad, last, tgt_rv, tmo;

  function automatic logic [CW-1:0] low_idx(input logic [VNUM-1:0] m);
    low_idx = '0;
    for (int i = VNUM-1; i >= 0; i--) if (m[i]) low_idx = CW'(i);
  endfunction

  assign rv2          = gbus_rvalid;
  assign rd2          = gbus_rdata;
  assign in_GBUS_ADDR = addr_r;
  assign gbus_wdata   = wdata_r;
  assign gbus_wen     = wen_r;
  assign gbus_ren     = ren_r;

  assign io.cmd_ready = rstn && (state == IDLE);
  assign io.wr_ready  = (state == WR);
  assign io.rd_valid  = (state == RD_OUT);
  assign io.rd_data   = rd_data_q;
  assign io.busy      = (state != IDLE);
  assign io.done      = (state == DONE);
  assign io.err       = (state == DONE) && err_q;

  assign cmd_fire = io.cmd_valid && io.cmd_ready;
  assign cmd_bad  = ({1'b0, io.cmd_row} >= HNUM_W) || (io.cmd_col_mask == '0);
  assign last     = (rem_q == GBUS_ADDR'(1));
  assign tgt_rv   = rv2[row_q][tgt_q];
  assign tmo      = (timer_q == TMAX);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (cmd_fire) begin
                  if (cmd_bad || io.cmd_len == '0) state_n = DONE;
                  else                             state_n = io.cmd_write ? WR : RD_ISSUE;
                end
      WR:       if (io.wr_valid && last) state_n = DONE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:  if (tgt_rv) state_n = RD_OUT;
                else if (tmo) state_n = DONE;
      RD_OUT:   if (io.rd_ready) state_n = last ? DONE : RD_ISSUE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_q <= '0; mask_q <= '0; tgt_q <= '0; addr_q <= '0; rem_q <= '0;
      timer_q <= '0; err_q <= 1'b0; rd_data_q <= '0;
      addr_r <= '0; wdata_r <= '0; wen_r <= '0; ren_r <= '0;
    end else begin
      // bus strobes are single-cycle: cleared unless re-issued below
      addr_r <= '0; wdata_r <= '0; wen_r <= '0; ren_r <= '0;
      case (state)
        IDLE: if (cmd_fire) begin
          row_q  <= io.cmd_row;
          mask_q <= io.cmd_col_mask;
          tgt_q  <= low_idx(io.cmd_col_mask);
          addr_q <= io.cmd_addr;
          rem_q  <= io.cmd_len;
          err_q  <= cmd_bad;
        end
        WR: if (io.wr_valid) begin
          wen_r[row_q]   <= mask_q;
          addr_r[row_q]  <= addr_q;
          wdata_r[row_q] <= io.wr_data;
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
        end
        RD_ISSUE: begin
          ren_r[row_q][tgt_q] <= 1'b1;
          addr_r[row_q]       <= addr_q;
          timer_q             <= '0;
        end
        // data arriving in the expiry cycle wins over the timeout
        RD_WAIT: begin
          if (tgt_rv)   rd_data_q <= rd2[row_q];
          else if (tmo) err_q     <= 1'b1;
          else          timer_q   <= timer_q + 1'b1;
        end
        RD_OUT: if (io.rd_ready) begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
